// File: rtl/seg7_frame_decoder.sv
// Display-readback monitor: recovers BCD digits from a multiplexed 7-segment bus
// and emits one glitch-filtered frame per full scan over a valid/ready handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no valid one-hot select on the bus
// S_TRACK   | new (sel,seg) pair seen, counting down the stability window
// S_CAPTURE | pair qualified; digit register is written on the next edge
// S_HOLD    | pair already captured, waiting for the bus to change
module seg7_frame_decoder #(
   parameter int NDIG   = 4,
   parameter int STABLE = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [6:0]          seg_in_i,
   input  logic [NDIG-1:0]     dig_sel_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [4*NDIG-1:0]   bcd_out_o,
   output logic [NDIG-1:0]     blank_mask_o,
   output logic [NDIG-1:0]     err_mask_o,
   output logic                overrun_o
);

   localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam int PW = NDIG + 7;

   typedef enum logic [1:0] {S_IDLE, S_TRACK, S_CAPTURE, S_HOLD} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [PW-1:0]       pair_q;
   logic [PW-1:0]       cur_pair;
   logic                sel_ok;
   logic                same_pair;

   logic [NDIG-1:0]     seen_q, seen_d;
   logic [4*NDIG-1:0]   nib_q, nib_d;
   logic [NDIG-1:0]     dblank_q, dblank_d;
   logic [NDIG-1:0]     derr_q, derr_d;

   logic                valid_q, valid_d;
   logic [4*NDIG-1:0]   bcd_q, bcd_d;
   logic [NDIG-1:0]     blank_q, blank_d;
   logic [NDIG-1:0]     err_q, err_d;
   logic                ovr_q, ovr_d;

   logic                capture;
   logic                frame_done;
   logic [NDIG-1:0]     cap_sel;
   logic [3:0]          dec_nib;
   logic                dec_blank;
   logic                dec_err;
   logic [NDIG-1:0]     seen_set;

   assign cur_pair  = {dig_sel_i, seg_in_i};
   assign sel_ok    = $onehot(dig_sel_i);
   assign same_pair = (cur_pair == pair_q);
   assign capture   = (state_q == S_CAPTURE);
   assign cap_sel   = pair_q[PW-1:7];

   always_comb begin
      dec_nib   = 4'hF;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (pair_q[6:0])
         7'h7E:   dec_nib = 4'h0;
         7'h30:   dec_nib = 4'h1;
         7'h6D:   dec_nib = 4'h2;
         7'h79:   dec_nib = 4'h3;
         7'h33:   dec_nib = 4'h4;
         7'h5B:   dec_nib = 4'h5;
         7'h5F:   dec_nib = 4'h6;
         7'h70:   dec_nib = 4'h7;
         7'h7F:   dec_nib = 4'h8;
         7'h7B:   dec_nib = 4'h9;
         7'h00: begin
            dec_nib   = 4'hA;
            dec_blank = 1'b1;
         end
         default: dec_err = 1'b1;
      endcase
   end

   // Any change of the pair (or an invalid select) restarts qualification.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!sel_ok) begin
         state_d = S_IDLE;
      end else if (!same_pair || state_q == S_IDLE) begin
         cnt_d   = CW'(STABLE - 1);
         state_d = (STABLE == 1) ? S_CAPTURE : S_TRACK;
      end else begin
         case (state_q)
            S_TRACK: begin
               if (cnt_q <= CW'(1)) state_d = S_CAPTURE;
               else                 cnt_d   = cnt_q - CW'(1);
            end
            S_CAPTURE: state_d = S_HOLD;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      nib_d      = nib_q;
      dblank_d   = dblank_q;
      derr_d     = derr_q;
      seen_set   = seen_q;
      seen_d     = seen_q;
      frame_done = 1'b0;
      if (capture) begin
         for (int i = 0; i < NDIG; i++) begin
            if (cap_sel[i]) begin
               nib_d[4*i +: 4] = dec_nib;
               dblank_d[i]     = dec_blank;
               derr_d[i]       = dec_err;
               seen_set[i]     = 1'b1;
            end
         end
         seen_d = seen_set;
         if (&seen_set) begin
            frame_done = 1'b1;
            seen_d     = '0;
         end
      end
   end

   // A completed frame is dropped rather than overwriting one still on offer.
   always_comb begin
      valid_d = valid_q;
      bcd_d   = bcd_q;
      blank_d = blank_q;
      err_d   = err_q;
      ovr_d   = ovr_q;
      if (valid_q && out_ready_i) valid_d = 1'b0;
      if (frame_done) begin
         if (valid_q && !out_ready_i) begin
            ovr_d = 1'b1;
         end else begin
            valid_d = 1'b1;
            bcd_d   = nib_d;
            blank_d = dblank_d;
            err_d   = derr_d;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pair_q   <= '0;
         seen_q   <= '0;
         nib_q    <= '0;
         dblank_q <= '0;
         derr_q   <= '0;
         valid_q  <= 1'b0;
         bcd_q    <= '0;
         blank_q  <= '0;
         err_q    <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pair_q   <= cur_pair;
         seen_q   <= seen_d;
         nib_q    <= nib_d;
         dblank_q <= dblank_d;
         derr_q   <= derr_d;
         valid_q  <= valid_d;
         bcd_q    <= bcd_d;
         blank_q  <= blank_d;
         err_q    <= err_d;
         ovr_q    <= ovr_d;
      end
   end

   assign out_valid_o  = valid_q;
   assign bcd_out_o    = bcd_q;
   assign blank_mask_o = blank_q;
   assign err_mask_o   = err_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: expected frames are queued as scans are
// driven and compared whenever the decoder hands a frame over.
module tb_seg7_frame_decoder;

   localparam int NDIG   = 4;
   localparam int STABLE = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [6:0]        seg;
   logic [NDIG-1:0]   sel;
   logic              ready;
   logic              out_valid;
   logic [4*NDIG-1:0] bcd;
   logic [NDIG-1:0]   blank;
   logic [NDIG-1:0]   err;
   logic              overrun;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] bcd;
      logic [3:0]  blank;
      logic [3:0]  err;
   } frame_t;

   frame_t exp_q[$];
   frame_t mon_f;

   seg7_frame_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .seg_in_i     (seg),
      .dig_sel_i    (sel),
      .out_valid_o  (out_valid),
      .out_ready_i  (ready),
      .bcd_out_o    (bcd),
      .blank_mask_o (blank),
      .err_mask_o   (err),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] s, input logic [6:0] g, input int n);
      sel = s;
      seg = g;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic scan(input logic [6:0] g0, input logic [6:0] g1,
                       input logic [6:0] g2, input logic [6:0] g3);
      drive(4'b0001, g0, STABLE);
      drive(4'b0010, g1, STABLE);
      drive(4'b0100, g2, STABLE);
      drive(4'b1000, g3, STABLE);
   endtask

   task automatic push(input logic [15:0] b, input logic [3:0] bl, input logic [3:0] er);
      frame_t f;
      f.bcd   = b;
      f.blank = bl;
      f.err   = er;
      exp_q.push_back(f);
   endtask

   // Handshake monitor: a transfer happens on the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid && ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_frame observed=%0h expected=none", bcd);
         end else begin
            mon_f = exp_q.pop_front();
            chk("frame_bcd", 32'(bcd), 32'(mon_f.bcd));
            chk("frame_blank", 32'(blank), 32'(mon_f.blank));
            chk("frame_err", 32'(err), 32'(mon_f.err));
         end
      end
   end

   initial begin
      rst   = 1'b1;
      sel   = '0;
      seg   = '0;
      ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_bcd", 32'(bcd), 0);
      chk("rst_blank", 32'(blank), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      drive(4'b0000, 7'h00, 6);
      chk("idle_valid", 32'(out_valid), 0);

      // basic scan and output latency
      push(16'h4321, 4'b0000, 4'b0000);
      scan(7'h30, 7'h6D, 7'h79, 7'h33);
      chk("valid_before_capture", 32'(out_valid), 0);
      drive(4'b0000, 7'h00, 1);
      chk("valid_at_capture", 32'(out_valid), 1);
      chk("held_bcd", 32'(bcd), 32'h4321);
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("valid_after_xfer", 32'(out_valid), 0);

      // short glitch ignored, full hold captured
      push(16'h4321, 4'b0000, 4'b0000);
      drive(4'b0001, 7'h30, STABLE);
      drive(4'b0010, 7'h7F, STABLE - 1);
      drive(4'b0010, 7'h6D, STABLE);
      drive(4'b0100, 7'h79, STABLE);
      drive(4'b1000, 7'h33, STABLE);
      drive(4'b0000, 7'h00, 1);
      push(16'h4381, 4'b0000, 4'b0000);
      scan(7'h30, 7'h7F, 7'h79, 7'h33);
      drive(4'b0000, 7'h00, 3);

      // error and blank patterns
      push(16'hAF50, 4'b1000, 4'b0100);
      scan(7'h7E, 7'h5B, 7'h55, 7'h00);
      drive(4'b0000, 7'h00, 3);

      // back-pressure: second frame dropped, overrun sticky
      ready = 1'b0;
      push(16'h4321, 4'b0000, 4'b0000);
      scan(7'h30, 7'h6D, 7'h79, 7'h33);
      drive(4'b0000, 7'h00, 1);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_overrun_clear", 32'(overrun), 0);
      scan(7'h5F, 7'h70, 7'h7F, 7'h7B);
      drive(4'b0000, 7'h00, 2);
      chk("bp_overrun_set", 32'(overrun), 1);
      chk("bp_bcd_held", 32'(bcd), 32'h4321);
      ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_after_xfer", 32'(out_valid), 0);
      chk("bp_overrun_sticky", 32'(overrun), 1);

      // reset mid-scan discards the partial frame; multi-hot never captures
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst2_overrun", 32'(overrun), 0);
      drive(4'b0001, 7'h30, STABLE);
      drive(4'b0010, 7'h6D, STABLE);
      rst = 1'b1;
      drive(4'b0000, 7'h00, 1);
      rst = 1'b0;
      drive(4'b0100, 7'h79, STABLE);
      drive(4'b1000, 7'h33, STABLE);
      drive(4'b0000, 7'h00, 3);
      chk("partial_no_frame", 32'(out_valid), 0);
      drive(4'b0011, 7'h7E, 10);
      chk("multihot_no_frame", 32'(out_valid), 0);
      push(16'h4375, 4'b0000, 4'b0000);
      drive(4'b0001, 7'h5B, STABLE);
      drive(4'b0010, 7'h70, STABLE);
      drive(4'b0000, 7'h00, 1);
      chk("completion_valid", 32'(out_valid), 1);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
